// File: rtl/iccm_read_arbiter.sv
// Round-robin arbiter sharing the single ICCM AXI read port between instruction fetch (s0)
// and the data/debug load path (s1); one transaction in flight, R channel steered to the winner.
module iccm_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              s_aclk,
  input  logic              s_areset,
  input  logic [ADDR_W-1:0] s0_axi_araddr,
  input  logic [1:0]        s0_axi_arburst,
  input  logic [ID_W-1:0]   s0_axi_arid,
  input  logic [7:0]        s0_axi_arlen,
  input  logic [2:0]        s0_axi_arsize,
  input  logic              s0_axi_arvalid,
  output logic              s0_axi_arready,
  output logic [DATA_W-1:0] s0_axi_rdata,
  output logic [ID_W-1:0]   s0_axi_rid,
  output logic [1:0]        s0_axi_rresp,
  output logic              s0_axi_rlast,
  output logic              s0_axi_rvalid,
  input  logic              s0_axi_rready,
  input  logic [ADDR_W-1:0] s1_axi_araddr,
  input  logic [1:0]        s1_axi_arburst,
  input  logic [ID_W-1:0]   s1_axi_arid,
  input  logic [7:0]        s1_axi_arlen,
  input  logic [2:0]        s1_axi_arsize,
  input  logic              s1_axi_arvalid,
  output logic              s1_axi_arready,
  output logic [DATA_W-1:0] s1_axi_rdata,
  output logic [ID_W-1:0]   s1_axi_rid,
  output logic [1:0]        s1_axi_rresp,
  output logic              s1_axi_rlast,
  output logic              s1_axi_rvalid,
  input  logic              s1_axi_rready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              grant,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic [7:0] beat_cnt;
  logic       any_req;
  logic       pick;
  logic       ar_hs;
  logic       r_hs;
  logic [7:0] sel_arlen;

  assign any_req   = s0_axi_arvalid | s1_axi_arvalid;
  // On contention the requester that did not win the previous transaction goes next.
  assign pick      = (s0_axi_arvalid & s1_axi_arvalid) ? ~last_grant : s1_axi_arvalid;
  assign sel_arlen = grant ? s1_axi_arlen : s0_axi_arlen;
  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) grant <= pick;
      if (ar_hs) beat_cnt <= sel_arlen;
      else if (r_hs && !m_axi_rlast) beat_cnt <= beat_cnt - 8'd1;
      if (r_hs && m_axi_rlast) last_grant <= grant;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (ar_hs) state_nxt = DATA;
      DATA:    if (r_hs && m_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    m_axi_araddr   = '0;
    m_axi_arburst  = '0;
    m_axi_arid     = '0;
    m_axi_arlen    = '0;
    m_axi_arsize   = '0;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    s0_axi_rdata   = '0;
    s0_axi_rid     = '0;
    s0_axi_rresp   = '0;
    s0_axi_rlast   = 1'b0;
    s1_axi_rdata   = '0;
    s1_axi_rid     = '0;
    s1_axi_rresp   = '0;
    s1_axi_rlast   = 1'b0;
    len_err        = 1'b0;
    unique case (state)
      ADDR: begin
        m_axi_arvalid  = 1'b1;
        m_axi_araddr   = grant ? s1_axi_araddr  : s0_axi_araddr;
        m_axi_arburst  = grant ? s1_axi_arburst : s0_axi_arburst;
        m_axi_arid     = grant ? s1_axi_arid    : s0_axi_arid;
        m_axi_arlen    = sel_arlen;
        m_axi_arsize   = grant ? s1_axi_arsize  : s0_axi_arsize;
        s0_axi_arready = ~grant & m_axi_arready;
        s1_axi_arready =  grant & m_axi_arready;
      end
      DATA: begin
        m_axi_rready  = grant ? s1_axi_rready : s0_axi_rready;
        s0_axi_rvalid = ~grant & m_axi_rvalid;
        s1_axi_rvalid =  grant & m_axi_rvalid;
        s0_axi_rdata  = m_axi_rdata;
        s0_axi_rid    = m_axi_rid;
        s0_axi_rresp  = m_axi_rresp;
        s0_axi_rlast  = m_axi_rlast;
        s1_axi_rdata  = m_axi_rdata;
        s1_axi_rid    = m_axi_rid;
        s1_axi_rresp  = m_axi_rresp;
        s1_axi_rlast  = m_axi_rlast;
        len_err       = r_hs & (m_axi_rlast ? (beat_cnt != 8'd0) : (beat_cnt == 8'd0));
      end
      default: ;
    endcase
  end

endmodule

// File: doc/iccm_read_arbiter.md
Name: iccm_read_arbiter

Overview:
- Shares the single ICCM AXI read port between two read requesters: requester 0 is the instruction fetch unit, requester 1 is the data/debug load path.
- Round-robin arbitration with one transaction outstanding at a time.
- Routes the R channel back to the granted requester only.
- Sits between the requesters and the iccm_wrapper read slave; the ICCM write channels bypass this block.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI read data width.
- ID_W, 4, AXI ID width; passed through unmodified.

Ports:
- s_aclk  in  1  clock; all logic rising-edge.
- s_areset  in  1  asynchronous, active-high reset.
- sN_axi_araddr/arburst/arid/arlen/arsize  in  ADDR_W/2/ID_W/8/3  AR payload from requester N (N=0,1).
- sN_axi_arvalid  in  1  AR valid, requester N.
- sN_axi_arready  out  1  AR ready, requester N.
- sN_axi_rdata/rid/rresp/rlast  out  DATA_W/ID_W/2/1  R payload to requester N.
- sN_axi_rvalid  out  1  R valid to requester N.
- sN_axi_rready  in  1  R ready from requester N.
- m_axi_araddr/arburst/arid/arlen/arsize  out  ADDR_W/2/ID_W/8/3  AR payload to ICCM.
- m_axi_arvalid  out  1  AR valid to ICCM.
- m_axi_arready  in  1  AR ready from ICCM.
- m_axi_rdata/rid/rresp/rlast  in  DATA_W/ID_W/2/1  R payload from ICCM.
- m_axi_rvalid  in  1  R valid from ICCM.
- m_axi_rready  out  1  R ready to ICCM.
- grant  out  1  index of the current/last granted requester.
- busy  out  1  high in ADDR or DATA.
- len_err  out  1  one-cycle pulse on a beat-count/rlast mismatch.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), beat_cnt=0.
  - All valid/ready outputs 0, busy=0, len_err=0, grant=0, payload outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - sN_axi_arready=0, m_axi_arvalid=0, m_axi_rready=0, all sN_axi_rvalid=0.
  - If exactly one arvalid is high, grant that requester.
  - If both are high, grant the requester != last_grant.
  - Grant is registered; next state is ADDR.
  - If neither is high, stay in IDLE.
- ADDR:
  - m_axi_arvalid=1; m_axi_ar* are combinationally muxed from the granted requester.
  - The requester holds its payload stable per AXI.
  - Granted sN_axi_arready = m_axi_arready; the other requester's arready = 0.
  - On m_axi_arvalid & m_axi_arready: beat_cnt <= granted arlen, state <= DATA.
- DATA:
  - m_axi_rready = granted sN_axi_rready.
  - Granted sN_axi_rvalid = m_axi_rvalid; the other requester's rvalid = 0.
  - rdata/rid/rresp/rlast are forwarded to both requesters; they are only meaningful with rvalid.
  - On each R handshake: if rlast=0, beat_cnt decrements.
  - If rlast=1: last_grant <= grant, state <= IDLE.
  - len_err pulses when rlast=1 with beat_cnt!=0, or rlast=0 with beat_cnt==0.
  - On len_err the beat is still forwarded and the FSM still follows rlast.
- Latency:
  - arvalid first sampled at edge k → m_axi_arvalid high from k+1.
  - First R beat is forwarded combinationally, zero added latency.
  - One mandatory IDLE bubble between consecutive transactions.
- Fairness:
  - With both requesters continuously requesting, grants alternate 0,1,0,1.
  - No requester waits more than one transaction.
- Requests: a requester deasserting arvalid while in IDLE is not granted. Once granted, the request is committed.
- Backpressure: R-channel stalls (granted rready=0) hold state; beat_cnt is unchanged.
- Bursts: arlen up to 255 is supported; rresp is passed through unmodified.
- Reset mid-transaction: immediately returns to IDLE with outputs deasserted. The ICCM shares the same reset and is assumed reset too; no drain.
- busy = (state!=IDLE). grant holds its value through IDLE.

Test Plan:
- Single fetch: s0 araddr=0x0, arlen=0, ICCM holds 0xDEADBEEF → m_axi_araddr=0x0 one cycle after arvalid; s0 receives rdata=0xDEADBEEF, rlast=1; s1_axi_rvalid is never high.
- Simultaneous requests after reset: s0@0x4, s1@0x8 asserted the same cycle → s0 served first (0xCAFEBABE), then after one IDLE cycle s1 gets 0x12345678; grant sequence 0 then 1.
- Continuous contention over 6 transactions → grant alternates 0,1,0,1,0,1; busy drops for exactly one cycle between each.
- Burst arlen=2 from s1@0x0 with s1_rready toggled 1,0,1,0,1 → three beats 0xDEADBEEF, 0xCAFEBABE, 0x12345678 delivered in order; transaction ends on the third beat's rlast; len_err stays 0.
- Length mismatch: arlen=1 but the ICCM model asserts rlast on beat 1 → len_err pulses one cycle; FSM returns to IDLE.
- Async reset asserted mid-burst in DATA → all valid/ready outputs 0 within the same cycle; busy=0, grant=0. After release, a new s0 request completes normally.
